alarm_controller: RTL and testbench
===================================

Name: alarm_controller

Overview:
- Alarm-time register and ringing state machine for the MM:SS alarm clock.
- Sits between the seconds/minutes up-counters (upstream) and the song player (downstream).
- Compares the running time with a user-set alarm time and drives the song player's play request.
- Supports arm/disarm, set mode, snooze and auto-timeout, and exports the alarm time and a display-select flag to the 7-segment mux.

Parameters:
- RING_SECS, 60, number of tick_1hz pulses a ring lasts before auto-stop.
- SNOOZE_SECS, 300, number of tick_1hz pulses spent in snooze before re-ringing.
- CNT_W, 10, width of the internal second counter; must hold max(RING_SECS, SNOOZE_SECS).

Ports:
- Clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- tick_1hz  in  1  one-Clock-cycle pulse, once per second, aligned with the seconds counter update
- cur_sec  in  6  current seconds, binary 0..59
- cur_min  in  6  current minutes, binary 0..59
- set_mode  in  1  level; high = edit alarm time
- inc_sec  in  1  debounced single-cycle pulse; +1 alarm seconds
- inc_min  in  1  debounced single-cycle pulse; +1 alarm minutes
- arm  in  1  single-cycle pulse; toggles armed/disarmed
- snooze  in  1  single-cycle pulse
- dismiss  in  1  single-cycle pulse
- alarm_sec  out  6  stored alarm seconds
- alarm_min  out  6  stored alarm minutes
- play_sound  out  1  high while ringing; feeds song player playSound
- armed  out  1  high in ARMED, RINGING or SNOOZE
- disp_alarm  out  1  high in SET; display mux shows alarm time instead of current time
- state_o  out  3  encoded state: IDLE=0, ARMED=1, RINGING=2, SNOOZE=3, SET=4

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is Clock. All state updates occur on the posedge of Clock.
- Reset values: state=IDLE, alarm_sec=0, alarm_min=0, sec_cnt=0, match_q=0, play_sound=0, armed=0, disp_alarm=0.
- Match detection:
  - match = (cur_min==alarm_min) && (cur_sec==alarm_sec), combinational.
  - match_q <= match every cycle, in all states.
  - trigger = match && !match_q.
  - Arming while the times already match does not ring; ringing waits for the next occurrence (next hour wrap).
- Input priority, same cycle: reset > set_mode > dismiss > snooze > arm > trigger/timeout.
- Any state, set_mode=1 -> SET next cycle. Current ring/snooze is abandoned and sec_cnt is cleared.
- SET:
  - inc_sec: alarm_sec <= (alarm_sec==59) ? 0 : alarm_sec+1.
  - inc_min: same rule applied to alarm_min.
  - inc_sec and inc_min in the same cycle both apply; no carry from seconds into minutes.
  - set_mode=0 -> IDLE. Editing always leaves the alarm disarmed.
  - inc_* pulses outside SET are ignored.
- IDLE: arm -> ARMED. Trigger is ignored.
- ARMED:
  - arm -> IDLE.
  - trigger -> RINGING with sec_cnt <= 0. play_sound goes high the cycle after the cycle where match first becomes true (1-cycle latency).
- RINGING:
  - dismiss -> ARMED.
  - snooze -> SNOOZE with sec_cnt <= 0.
  - Otherwise each tick_1hz: if sec_cnt==RING_SECS-1 -> ARMED (auto-stop), else sec_cnt+1.
  - arm is ignored.
- SNOOZE:
  - dismiss -> ARMED.
  - Each tick_1hz: if sec_cnt==SNOOZE_SECS-1 -> RINGING with sec_cnt <= 0, else sec_cnt+1.
  - arm and snooze are ignored.
  - Matches during SNOOZE do not restart anything.
- Outputs are registered, decoded from the next-state value:
  - play_sound = (state==RINGING)
  - armed = state in {ARMED, RINGING, SNOOZE}
  - disp_alarm = (state==SET)
- tick_1hz coinciding with dismiss or snooze: the button wins and the tick is not counted.
- Reset mid-ring: play_sound is low the cycle after reset is sampled, and the alarm time returns to 00:00.

Test Plan:
- Reset, set_mode=1, 3x inc_min, 5x inc_sec, set_mode=0 -> alarm_min=3, alarm_sec=5, state_o=0, disp_alarm 1 then 0.
- Alarm 59:59 in SET, pulse inc_sec and inc_min in the same cycle -> alarm 00:00, no carry.
- Alarm 01:00, arm, drive cur time 00:59 -> 01:00 -> play_sound=1 exactly one cycle after cur=01:00 appears; state_o=2.
- Ringing, apply 60 tick_1hz with RING_SECS=60 -> play_sound falls after the 60th tick; state_o=1; holding cur=01:00 does not retrigger.
- Ringing, snooze, 300 ticks -> play_sound=0 throughout, then 1 after the 300th tick; then dismiss -> state_o=1, play_sound=0.
- Arm while cur==alarm -> no ring. Then assert reset while ringing -> next cycle play_sound=0, alarm 00:00, state_o=0.

Source files
------------

// File: rtl/alarm_controller.sv
// alarm_controller
//   Alarm-time register and ringing state machine for the MM:SS alarm clock.
//   It compares the running time from the seconds/minutes counters with a
//   user-set alarm time and drives the song player's play request. It also
//   handles arm/disarm, alarm-time editing, snooze and ring auto-timeout.
//
// Ports
//   Clock, reset            system clock; synchronous active-high reset
//   tick_1hz                one-cycle pulse per second
//   cur_sec, cur_min        running time, binary 0..59
//   set_mode                level; high = edit alarm time
//   inc_sec, inc_min        single-cycle pulses; +1 alarm sec/min while in SET
//   arm, snooze, dismiss    single-cycle user pulses
//   alarm_sec, alarm_min    stored alarm time
//   play_sound              high while ringing
//   armed                   high in ARMED, RINGING or SNOOZE
//   disp_alarm              high in SET (display shows the alarm time)
//   state_o                 IDLE=0, ARMED=1, RINGING=2, SNOOZE=3, SET=4
module alarm_controller #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300,
    parameter int CNT_W       = 10
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic [5:0] cur_sec,
    input  logic [5:0] cur_min,
    input  logic       set_mode,
    input  logic       inc_sec,
    input  logic       inc_min,
    input  logic       arm,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [5:0] alarm_sec,
    output logic [5:0] alarm_min,
    output logic       play_sound,
    output logic       armed,
    output logic       disp_alarm,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARMED   = 3'd1,
        S_RINGING = 3'd2,
        S_SNOOZE  = 3'd3,
        S_SET     = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] RING_LAST   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LAST = CNT_W'(SNOOZE_SECS - 1);

    state_t           r_state, w_next_state;
    logic [CNT_W-1:0] r_sec_cnt, w_next_cnt;
    logic [5:0]       r_alarm_sec, r_alarm_min, w_next_asec, w_next_amin;
    logic             r_match_q, r_play, r_armed, r_disp;
    logic             w_match, w_trigger;

    // Edge-detect the match so a ring fires only when the time first reaches
    // the alarm; arming while already matching waits for the next hour.
    assign w_match   = (cur_min == r_alarm_min) && (cur_sec == r_alarm_sec);
    assign w_trigger = w_match && !r_match_q;

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_sec_cnt;
        w_next_asec  = r_alarm_sec;
        w_next_amin  = r_alarm_min;

        // Edits apply whenever we are in SET; seconds never carry into minutes.
        if (r_state == S_SET) begin
            if (inc_sec) w_next_asec = (r_alarm_sec == 6'd59) ? 6'd0 : r_alarm_sec + 6'd1;
            if (inc_min) w_next_amin = (r_alarm_min == 6'd59) ? 6'd0 : r_alarm_min + 6'd1;
        end

        if (set_mode) begin
            w_next_state = S_SET;
            w_next_cnt   = '0;
        end else begin
            unique case (r_state)
                S_SET:  w_next_state = S_IDLE;
                S_IDLE: if (arm) w_next_state = S_ARMED;
                S_ARMED: begin
                    if (arm) begin
                        w_next_state = S_IDLE;
                    end else if (w_trigger) begin
                        w_next_state = S_RINGING;
                        w_next_cnt   = '0;
                    end
                end
                S_RINGING: begin
                    // Buttons win over a coincident tick; the tick is dropped.
                    if (dismiss) begin
                        w_next_state = S_ARMED;
                        w_next_cnt   = '0;
                    end else if (snooze) begin
                        w_next_state = S_SNOOZE;
                        w_next_cnt   = '0;
                    end else if (tick_1hz) begin
                        if (r_sec_cnt == RING_LAST) begin
                            w_next_state = S_ARMED;
                            w_next_cnt   = '0;
                        end else begin
                            w_next_cnt = r_sec_cnt + 1'b1;
                        end
                    end
                end
                S_SNOOZE: begin
                    if (dismiss) begin
                        w_next_state = S_ARMED;
                        w_next_cnt   = '0;
                    end else if (tick_1hz) begin
                        if (r_sec_cnt == SNOOZE_LAST) begin
                            w_next_state = S_RINGING;
                            w_next_cnt   = '0;
                        end else begin
                            w_next_cnt = r_sec_cnt + 1'b1;
                        end
                    end
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_sec_cnt   <= '0;
            r_alarm_sec <= '0;
            r_alarm_min <= '0;
            r_match_q   <= 1'b0;
            r_play      <= 1'b0;
            r_armed     <= 1'b0;
            r_disp      <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_sec_cnt   <= w_next_cnt;
            r_alarm_sec <= w_next_asec;
            r_alarm_min <= w_next_amin;
            r_match_q   <= w_match;
            // Outputs are registered decodes of the next state so they line up
            // with state_o without a combinational path to the pins.
            r_play      <= (w_next_state == S_RINGING);
            r_armed     <= (w_next_state == S_ARMED) || (w_next_state == S_RINGING) ||
                           (w_next_state == S_SNOOZE);
            r_disp      <= (w_next_state == S_SET);
        end
    end

    assign alarm_sec  = r_alarm_sec;
    assign alarm_min  = r_alarm_min;
    assign play_sound = r_play;
    assign armed      = r_armed;
    assign disp_alarm = r_disp;
    assign state_o    = r_state;

endmodule

// File: tb/tb_alarm_controller.sv
module tb_alarm_controller;
  localparam int RING = 60;
  localparam int SNZ  = 300;

  logic       Clock = 1'b0;
  logic       reset = 1'b1;
  logic       tick_1hz = 1'b0, set_mode = 1'b0, inc_sec = 1'b0, inc_min = 1'b0;
  logic       arm = 1'b0, snooze = 1'b0, dismiss = 1'b0;
  logic [5:0] cur_sec = '0, cur_min = '0;
  logic [5:0] alarm_sec, alarm_min;
  logic       play_sound, armed, disp_alarm;
  logic [2:0] state_o;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: alarm time in plain ints, ring/snooze tracked as a
  // countdown of remaining seconds.
  int m_st = 0, m_as = 0, m_am = 0, m_left = 0;
  bit m_prev_match = 0;

  alarm_controller #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .CNT_W(10)) dut (
    .Clock(Clock), .reset(reset), .tick_1hz(tick_1hz),
    .cur_sec(cur_sec), .cur_min(cur_min), .set_mode(set_mode),
    .inc_sec(inc_sec), .inc_min(inc_min), .arm(arm), .snooze(snooze),
    .dismiss(dismiss), .alarm_sec(alarm_sec), .alarm_min(alarm_min),
    .play_sound(play_sound), .armed(armed), .disp_alarm(disp_alarm),
    .state_o(state_o)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    bit now_match, fresh;
    if (reset) begin
      m_st = 0; m_as = 0; m_am = 0; m_left = 0; m_prev_match = 0;
      return;
    end
    now_match = (int'(cur_min) == m_am) && (int'(cur_sec) == m_as);
    fresh = now_match && !m_prev_match;
    m_prev_match = now_match;
    if (m_st == 4) begin
      if (inc_sec) m_as = (m_as + 1) % 60;
      if (inc_min) m_am = (m_am + 1) % 60;
    end
    if (set_mode) m_st = 4;
    else case (m_st)
      4: m_st = 0;
      0: if (arm) m_st = 1;
      1: if (arm) m_st = 0; else if (fresh) begin m_st = 2; m_left = RING; end
      2: if (dismiss) m_st = 1;
         else if (snooze) begin m_st = 3; m_left = SNZ; end
         else if (tick_1hz) begin m_left--; if (m_left == 0) m_st = 1; end
      3: if (dismiss) m_st = 1;
         else if (tick_1hz) begin m_left--; if (m_left == 0) begin m_st = 2; m_left = RING; end end
      default: m_st = 0;
    endcase
  endtask

  // One clock: model consumes the inputs present at the edge, outputs are
  // compared 1 ns later, single-cycle pulses are then dropped.
  task automatic cyc();
    @(posedge Clock);
    model_step();
    #1;
    chk("state_o", state_o, m_st);
    chk("play_sound", play_sound, m_st == 2);
    chk("armed", armed, m_st >= 1 && m_st <= 3);
    chk("disp_alarm", disp_alarm, m_st == 4);
    chk("alarm_sec", alarm_sec, m_as);
    chk("alarm_min", alarm_min, m_am);
    tick_1hz = 0; inc_sec = 0; inc_min = 0; arm = 0; snooze = 0; dismiss = 0;
  endtask

  task automatic cur(input int mm, input int ss);
    cur_min = 6'(mm); cur_sec = 6'(ss);
  endtask

  initial begin
    // Reset state
    reset = 1; cyc(); cyc();
    chk("rst_state", state_o, 0); chk("rst_play", play_sound, 0);
    chk("rst_asec", alarm_sec, 0); chk("rst_amin", alarm_min, 0);
    reset = 0; cur(10, 30); cyc();

    // Set 03:05
    set_mode = 1; cyc();
    chk("disp_in_set", disp_alarm, 1);
    for (int i = 0; i < 3; i++) begin inc_min = 1; cyc(); end
    for (int i = 0; i < 5; i++) begin inc_sec = 1; cyc(); end
    set_mode = 0; cyc();
    chk("set_min3", alarm_min, 3); chk("set_sec5", alarm_sec, 5);
    chk("set_exit_state", state_o, 0); chk("disp_after_set", disp_alarm, 0);

    // Go to 59:59, then both increments wrap with no carry
    set_mode = 1; cyc();
    for (int i = 0; i < 56; i++) begin inc_min = 1; inc_sec = (i < 54); cyc(); end
    chk("a5959_min", alarm_min, 59); chk("a5959_sec", alarm_sec, 59);
    inc_min = 1; inc_sec = 1; cyc();
    chk("wrap_min", alarm_min, 0); chk("wrap_sec", alarm_sec, 0);

    // Alarm 01:00, arm, time 00:59 -> 01:00
    inc_min = 1; cyc(); set_mode = 0; cyc();
    cur(0, 59); arm = 1; cyc(); cyc();
    chk("armed_state", state_o, 1); chk("no_ring_yet", play_sound, 0);
    cur(1, 0); cyc();
    chk("ring_latency", play_sound, 1); chk("ring_state", state_o, 2);

    // 60 ticks with cur held at 01:00 -> auto stop, no retrigger
    for (int i = 0; i < RING; i++) begin
      if (i == RING - 1) chk("still_ringing", play_sound, 1);
      tick_1hz = 1; cyc(); cyc();
    end
    chk("auto_stop", play_sound, 0); chk("auto_stop_st", state_o, 1);
    repeat (5) cyc();
    chk("no_retrig", play_sound, 0);

    // Re-ring, snooze 300 ticks, dismiss
    cur(0, 59); cyc(); cur(1, 0); cyc();
    chk("ring2", play_sound, 1);
    snooze = 1; cyc();
    chk("snooze_st", state_o, 3);
    for (int i = 0; i < SNZ; i++) begin
      if (i == SNZ - 1) chk("snooze_quiet", play_sound, 0);
      tick_1hz = 1; cyc();
    end
    chk("snooze_rering", play_sound, 1);
    dismiss = 1; tick_1hz = 1; cyc();
    chk("dismiss_st", state_o, 1); chk("dismiss_play", play_sound, 0);

    // Arm while already matching: no ring
    arm = 1; cyc(); chk("disarm", state_o, 0);
    cur(0, 59); cyc(); cur(1, 0); cyc(); cyc();
    arm = 1; cyc(); repeat (3) cyc();
    chk("arm_on_match", play_sound, 0); chk("arm_on_match_st", state_o, 1);

    // Reset mid-ring
    cur(0, 59); cyc(); cur(1, 0); cyc();
    chk("ring3", play_sound, 1);
    reset = 1; cyc(); reset = 0;
    chk("rst_ring_play", play_sound, 0); chk("rst_ring_st", state_o, 0);
    chk("rst_ring_amin", alarm_min, 0); chk("rst_ring_asec", alarm_sec, 0);

    // Randomized traffic over a small time window so matches are frequent
    for (int n = 0; n < 20000; n++) begin
      if ($urandom_range(0, 59) == 0) set_mode = ~set_mode;
      reset    = ($urandom_range(0, 999) == 0);
      tick_1hz = ($urandom_range(0, 1) == 0);
      inc_sec  = ($urandom_range(0, 3) == 0);
      inc_min  = ($urandom_range(0, 7) == 0);
      arm      = ($urandom_range(0, 15) == 0);
      snooze   = ($urandom_range(0, 63) == 0);
      dismiss  = ($urandom_range(0, 127) == 0);
      if ($urandom_range(0, 3) == 0) cur($urandom_range(0, 1), $urandom_range(0, 3));
      // Pull the alarm back into the window so triggers keep happening.
      if (m_st == 4 && (m_as > 3 || m_am > 1)) begin inc_sec = (m_as != 0); inc_min = (m_am > 1); end
      cyc();
    end
    reset = 0; set_mode = 0; cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
